cmd_rsp_initiator: RTL and testbench

CMD_RSP_INITIATOR -- requirements
Module: cmd_rsp_initiator

---
 rtl/cmd_rsp_initiator_pkg.sv | 25 ++
 rtl/cmd_rsp_timeout_timer.sv | 43 ++++
 rtl/cmd_rsp_initiator.sv | 199 +++++++++++++++++++
 tb/tb_cmd_rsp_initiator.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_rsp_initiator_pkg.sv
// Shared types, defaults and helpers for the command/response initiator.
package cmd_rsp_initiator_pkg;

    localparam int unsigned FID_W                  = 10;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;
    localparam logic [31:0] DEFAULT_TIMEOUT_DATA   = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CMD      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_RESULT   = 2'd3
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cmd_rsp_timeout_timer.sv
// Cycle counter measuring how long the outstanding command has been in flight.
module cmd_rsp_timeout_timer
    import cmd_rsp_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned   CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = (count_q == LAST);

    // Next count: restart on a new command, hold once the terminal value is reached.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CW'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cmd_rsp_initiator.sv
// Issues one command at a time to an accelerator, collects its response or
// aborts on timeout, and presents the result upstream.
module cmd_rsp_initiator
    import cmd_rsp_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [31:0] TIMEOUT_DATA   = DEFAULT_TIMEOUT_DATA
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [FID_W-1:0] req_function_id,
    input  logic [31:0]      req_inputs_0,
    input  logic [31:0]      req_inputs_1,
    output logic             cmd_valid,
    output logic [FID_W-1:0] cmd_function_id,
    output logic [31:0]      cmd_inputs_0,
    output logic [31:0]      cmd_inputs_1,
    input  logic             cmd_ready,
    input  logic             rsp_valid,
    input  logic [31:0]      rsp_outputs_0,
    output logic             rsp_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [FID_W-1:0] res_function_id,
    output logic             res_timeout,
    input  logic             cmd_int,
    input  logic             irq_clear,
    output logic             irq_pending,
    output logic             busy,
    output logic [7:0]       stray_rsp_cnt
);

    state_e           state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [FID_W-1:0] cmd_function_id_q, cmd_function_id_d;
    logic [31:0]      cmd_inputs_0_q, cmd_inputs_0_d;
    logic [31:0]      cmd_inputs_1_q, cmd_inputs_1_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [FID_W-1:0] res_function_id_q, res_function_id_d;
    logic             res_timeout_q, res_timeout_d;
    logic             irq_pending_q, irq_pending_d;
    logic             busy_q, busy_d;
    logic [7:0]       stray_cnt_q, stray_cnt_d;

    logic accept_s;
    logic capture_s;
    logic stray_s;
    logic timer_enable_s;
    logic timer_expired_s;

    assign accept_s       = (state_q == ST_IDLE) && req_valid && req_ready_q;
    // A response is only accepted while the command is being (or has been) taken.
    assign capture_s      = rsp_valid &&
                            (((state_q == ST_CMD) && cmd_ready) || (state_q == ST_WAIT_RSP));
    assign stray_s        = rsp_valid && !capture_s;
    assign timer_enable_s = (state_q == ST_CMD) || (state_q == ST_WAIT_RSP);

    cmd_rsp_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept_s),
        .enable  (timer_enable_s),
        .expired (timer_expired_s)
    );

    // Next-state and next-output computation for the transaction FSM and status.
    always_comb begin
        state_d           = state_q;
        cmd_valid_d       = cmd_valid_q;
        cmd_function_id_d = cmd_function_id_q;
        cmd_inputs_0_d    = cmd_inputs_0_q;
        cmd_inputs_1_d    = cmd_inputs_1_q;
        res_valid_d       = res_valid_q;
        res_data_d        = res_data_q;
        res_function_id_d = res_function_id_q;
        res_timeout_d     = res_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d           = ST_CMD;
                    cmd_valid_d       = 1'b1;
                    cmd_function_id_d = req_function_id;
                    cmd_inputs_0_d    = req_inputs_0;
                    cmd_inputs_1_d    = req_inputs_1;
                    res_function_id_d = req_function_id;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD, ST_WAIT_RSP: begin
                if (capture_s) begin
                    state_d       = ST_RESULT;
                    cmd_valid_d   = 1'b0;
                    res_valid_d   = 1'b1;
                    res_data_d    = rsp_outputs_0;
                    res_timeout_d = 1'b0;
                end else if (timer_expired_s) begin
                    state_d       = ST_RESULT;
                    cmd_valid_d   = 1'b0;
                    res_valid_d   = 1'b1;
                    res_data_d    = TIMEOUT_DATA;
                    res_timeout_d = 1'b1;
                end else if ((state_q == ST_CMD) && cmd_ready) begin
                    state_d     = ST_WAIT_RSP;
                    cmd_valid_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end else begin
                    state_d = ST_RESULT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_valid_d = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);

        if (stray_s) begin
            stray_cnt_d = sat_inc8(stray_cnt_q);
        end else begin
            stray_cnt_d = stray_cnt_q;
        end

        // Setting wins over clearing so a coincident interrupt is never lost.
        if (cmd_int) begin
            irq_pending_d = 1'b1;
        end else if (irq_clear) begin
            irq_pending_d = 1'b0;
        end else begin
            irq_pending_d = irq_pending_q;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            req_ready_q       <= 1'b0;
            cmd_valid_q       <= 1'b0;
            cmd_function_id_q <= '0;
            cmd_inputs_0_q    <= 32'd0;
            cmd_inputs_1_q    <= 32'd0;
            res_valid_q       <= 1'b0;
            res_data_q        <= 32'd0;
            res_function_id_q <= '0;
            res_timeout_q     <= 1'b0;
            irq_pending_q     <= 1'b0;
            busy_q            <= 1'b0;
            stray_cnt_q       <= 8'd0;
        end else begin
            state_q           <= state_d;
            req_ready_q       <= req_ready_d;
            cmd_valid_q       <= cmd_valid_d;
            cmd_function_id_q <= cmd_function_id_d;
            cmd_inputs_0_q    <= cmd_inputs_0_d;
            cmd_inputs_1_q    <= cmd_inputs_1_d;
            res_valid_q       <= res_valid_d;
            res_data_q        <= res_data_d;
            res_function_id_q <= res_function_id_d;
            res_timeout_q     <= res_timeout_d;
            irq_pending_q     <= irq_pending_d;
            busy_q            <= busy_d;
            stray_cnt_q       <= stray_cnt_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign cmd_valid       = cmd_valid_q;
    assign cmd_function_id = cmd_function_id_q;
    assign cmd_inputs_0    = cmd_inputs_0_q;
    assign cmd_inputs_1    = cmd_inputs_1_q;
    assign rsp_ready       = 1'b1;
    assign res_valid       = res_valid_q;
    assign res_data        = res_data_q;
    assign res_function_id = res_function_id_q;
    assign res_timeout     = res_timeout_q;
    assign irq_pending     = irq_pending_q;
    assign busy            = busy_q;
    assign stray_rsp_cnt   = stray_cnt_q;

endmodule

// File: tb/tb_cmd_rsp_initiator.sv
// Directed and randomized bench for cmd_rsp_initiator with a transaction-level reference model.
module tb_cmd_rsp_initiator;

    localparam int unsigned TMO   = 16;
    localparam logic [31:0] TDATA = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_function_id;
    logic [31:0] req_inputs_0;
    logic [31:0] req_inputs_1;
    logic        cmd_valid;
    logic [9:0]  cmd_function_id;
    logic [31:0] cmd_inputs_0;
    logic [31:0] cmd_inputs_1;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [31:0] rsp_outputs_0;
    logic        rsp_ready;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [9:0]  res_function_id;
    logic        res_timeout;
    logic        cmd_int;
    logic        irq_clear;
    logic        irq_pending;
    logic        busy;
    logic [7:0]  stray_rsp_cnt;

    cmd_rsp_initiator #(
        .TIMEOUT_CYCLES (TMO),
        .TIMEOUT_DATA   (TDATA)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_function_id (req_function_id),
        .req_inputs_0    (req_inputs_0),
        .req_inputs_1    (req_inputs_1),
        .cmd_valid       (cmd_valid),
        .cmd_function_id (cmd_function_id),
        .cmd_inputs_0    (cmd_inputs_0),
        .cmd_inputs_1    (cmd_inputs_1),
        .cmd_ready       (cmd_ready),
        .rsp_valid       (rsp_valid),
        .rsp_outputs_0   (rsp_outputs_0),
        .rsp_ready       (rsp_ready),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_data        (res_data),
        .res_function_id (res_function_id),
        .res_timeout     (res_timeout),
        .cmd_int         (cmd_int),
        .irq_clear       (irq_clear),
        .irq_pending     (irq_pending),
        .busy            (busy),
        .stray_rsp_cnt   (stray_rsp_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model: one transaction record (in flight / command offered /
    // result offered), its age, and the status counters.
    bit          m_txn;
    bit          m_cmd_out;
    bit          m_res_out;
    bit          m_after_reset;
    int          m_age;
    logic [9:0]  m_fid;
    logic [31:0] m_in0;
    logic [31:0] m_in1;
    logic [31:0] m_rdata;
    bit          m_rto;
    int          m_stray;
    bit          m_irq;

    task automatic model_step();
        bit acc;
        bit window;
        if (reset) begin
            m_txn = 1'b0; m_cmd_out = 1'b0; m_res_out = 1'b0; m_after_reset = 1'b1;
            m_age = 0; m_fid = 10'd0; m_in0 = 32'd0; m_in1 = 32'd0;
            m_rdata = 32'd0; m_rto = 1'b0; m_stray = 0; m_irq = 1'b0;
        end else begin
            acc    = !m_txn && !m_after_reset && req_valid;
            window = m_txn && !m_res_out && (!m_cmd_out || cmd_ready);
            m_after_reset = 1'b0;
            if (cmd_int) m_irq = 1'b1;
            else if (irq_clear) m_irq = 1'b0;
            if (rsp_valid && !window && m_stray < 255) m_stray++;
            if (acc) begin
                m_txn = 1'b1; m_cmd_out = 1'b1; m_age = 0;
                m_fid = req_function_id; m_in0 = req_inputs_0; m_in1 = req_inputs_1;
            end else if (m_txn && m_res_out) begin
                if (res_ready) begin
                    m_txn = 1'b0; m_res_out = 1'b0;
                end
            end else if (m_txn) begin
                if (rsp_valid && window) begin
                    m_rdata = rsp_outputs_0; m_rto = 1'b0; m_res_out = 1'b1; m_cmd_out = 1'b0;
                end else if (m_age == int'(TMO) - 1) begin
                    m_rdata = TDATA; m_rto = 1'b1; m_res_out = 1'b1; m_cmd_out = 1'b0;
                end else begin
                    if (cmd_ready) m_cmd_out = 1'b0;
                    m_age++;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("req_ready",       32'(req_ready),       32'(!m_txn && !m_after_reset));
                check("cmd_valid",       32'(cmd_valid),       32'(m_cmd_out));
                check("cmd_function_id", 32'(cmd_function_id), 32'(m_fid));
                check("cmd_inputs_0",    cmd_inputs_0,         m_in0);
                check("cmd_inputs_1",    cmd_inputs_1,         m_in1);
                check("rsp_ready",       32'(rsp_ready),       32'd1);
                check("res_valid",       32'(res_valid),       32'(m_res_out));
                check("res_data",        res_data,             m_rdata);
                check("res_function_id", 32'(res_function_id), 32'(m_fid));
                check("res_timeout",     32'(res_timeout),     32'(m_rto));
                check("irq_pending",     32'(irq_pending),     32'(m_irq));
                check("busy",            32'(busy),            32'(m_txn));
                check("stray_rsp_cnt",   32'(stray_rsp_cnt),   32'(m_stray));
            end
        end
    end

    task automatic idle_inputs();
        req_valid = 1'b0; req_function_id = 10'd0; req_inputs_0 = 32'd0; req_inputs_1 = 32'd0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_outputs_0 = 32'd0; res_ready = 1'b0;
        cmd_int = 1'b0; irq_clear = 1'b0;
    endtask

    task automatic issue(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1; req_function_id = fid; req_inputs_0 = a; req_inputs_1 = b;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        int n;
        int rsp_pct;
        int rdy_pct;
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_res_data",  res_data,       32'd0);
        check("rst_cmd_fid",   32'(cmd_function_id), 32'd0);
        check("rst_stray",     32'(stray_rsp_cnt),   32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);

        // Basic command with response three cycles after the command handshake.
        issue(10'h201, 32'd5, 32'd7);
        cmd_ready = 1'b1;
        check("t1_cmd_valid", 32'(cmd_valid), 32'd1);
        check("t1_cmd_fid",   32'(cmd_function_id), 32'h201);
        check("t1_cmd_in0",   cmd_inputs_0, 32'd5);
        check("t1_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        cmd_ready = 1'b0;
        check("t1_cmd_dropped", 32'(cmd_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rsp_valid = 1'b1; rsp_outputs_0 = 32'h0000_000C;
        @(negedge clk);
        rsp_valid = 1'b0;
        check("t1_res_valid",   32'(res_valid), 32'd1);
        check("t1_res_data",    res_data, 32'h0000_000C);
        check("t1_res_timeout", 32'(res_timeout), 32'd0);
        check("t1_res_fid",     32'(res_function_id), 32'h201);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("t1_back_idle", 32'(req_ready), 32'd1);

        // Zero-latency accelerator: command and response in the same cycle.
        issue(10'h0AB, 32'd1, 32'd2);
        cmd_ready = 1'b1; rsp_valid = 1'b1; rsp_outputs_0 = 32'hABCD_0001;
        @(negedge clk);
        cmd_ready = 1'b0; rsp_valid = 1'b0;
        check("t2_res_valid", 32'(res_valid), 32'd1);
        check("t2_res_data",  res_data, 32'hABCD_0001);
        check("t2_no_stray",  32'(stray_rsp_cnt), 32'd0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Command never accepted: abort after TMO cycles of cmd_valid.
        issue(10'h3FF, 32'd9, 32'd9);
        n = 0;
        for (int i = 0; i < 40 && cmd_valid; i++) begin
            n++;
            @(negedge clk);
        end
        check("t3_cmd_valid_cycles", 32'(n), 32'd16);
        check("t3_res_valid",   32'(res_valid), 32'd1);
        check("t3_res_data",    res_data, 32'hDEAD_BEEF);
        check("t3_res_timeout", 32'(res_timeout), 32'd1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Late response after timeout is a stray and leaves the result alone.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(10'h111, 32'd3, 32'd4);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        repeat (18) @(negedge clk);
        rsp_valid = 1'b1; rsp_outputs_0 = 32'h1234_5678;
        @(negedge clk);
        rsp_valid = 1'b0;
        check("t4_stray",       32'(stray_rsp_cnt), 32'd1);
        check("t4_res_data",    res_data, 32'hDEAD_BEEF);
        check("t4_res_timeout", 32'(res_timeout), 32'd1);

        // Result held while upstream stalls.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_res_valid_hold", 32'(res_valid), 32'd1);
            check("t5_res_data_hold",  res_data, 32'hDEAD_BEEF);
            check("t5_req_ready_low",  32'(req_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("t5_released", 32'(res_valid), 32'd0);
        rsp_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rsp_outputs_0 = $urandom;
            @(negedge clk);
        end
        rsp_valid = 1'b0;
        check("t5_stray_saturated", 32'(stray_rsp_cnt), 32'd255);

        // Reset in the middle of a command, then interrupt flag priority.
        issue(10'h222, 32'd1, 32'd1);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        @(negedge clk);
        check("t6_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_busy_after",      32'(busy), 32'd0);
        check("t6_res_valid_after", 32'(res_valid), 32'd0);
        check("t6_cmd_valid_after", 32'(cmd_valid), 32'd0);
        @(negedge clk);
        cmd_int = 1'b1; irq_clear = 1'b1;
        @(negedge clk);
        cmd_int = 1'b0; irq_clear = 1'b0;
        check("t6_irq_set_wins", 32'(irq_pending), 32'd1);
        irq_clear = 1'b1;
        @(negedge clk);
        irq_clear = 1'b0;
        check("t6_irq_cleared", 32'(irq_pending), 32'd0);

        // Randomized traffic in segments of varying handshake density.
        for (int s = 0; s < 20; s++) begin
            rsp_pct = int'($urandom_range(0, 30));
            rdy_pct = int'($urandom_range(0, 60));
            for (int c = 0; c < 200; c++) begin
                reset           = ($urandom_range(0, 199) == 0);
                req_valid       = 1'($urandom_range(0, 1));
                req_function_id = 10'($urandom);
                req_inputs_0    = $urandom;
                req_inputs_1    = $urandom;
                cmd_ready       = (int'($urandom_range(0, 99)) < rdy_pct);
                rsp_valid       = (int'($urandom_range(0, 99)) < rsp_pct);
                rsp_outputs_0   = $urandom;
                res_ready       = 1'($urandom_range(0, 1));
                cmd_int         = ($urandom_range(0, 19) == 0);
                irq_clear       = ($urandom_range(0, 19) == 0);
                @(negedge clk);
            end
        end

        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
